// File: rtl/evt_pkg.sv
// Shared types for the event-trigger scheduler and its neighbours in evt_top.
package evt_pkg;

    // Pulse FSM states
    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StGap
    } evt_state_e;

    // mode_i encodings: bit 0 selects the periodic source, bit 1 the IMU source
    typedef enum logic [1:0] {
        MODE_NONE     = 2'd0,
        MODE_PERIODIC = 2'd1,
        MODE_IMU      = 2'd2,
        MODE_BOTH     = 2'd3
    } evt_mode_e;

    localparam int unsigned EVT_ID_WIDTH = 5;

    // Trigger-event record handed to the event-stream merger
    typedef struct packed {
        logic [EVT_ID_WIDTH-1:0] id;
        logic                    pol;
    } trig_evt_t;

endpackage

// File: rtl/evt_sync_edge.sv
// N-stage synchronizer for an asynchronous level, followed by a registered
// single-cycle rising-edge strobe.
module evt_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic [STAGES-1:0] r_sync;
    logic              r_dly;
    logic              r_rise;

    // Synchronizer chain, delay flop for edge detection and registered strobe
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], async_i};
            r_dly  <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_dly;
        end
    end

    assign rise_o = r_rise;

endmodule

// File: rtl/evt_trig_scheduler.sv
// Trigger scheduler: periodic timer and/or IMU interrupt requests drive a pulse
// FSM on the sensor EXTTRIG pin; every pulse edge emits an (id, pol) event.
module evt_trig_scheduler
    import evt_pkg::*;
#(
    parameter int unsigned TICK_WIDTH  = 24,
    parameter int unsigned ID_WIDTH    = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic [1:0]            mode_i,
    input  logic [TICK_WIDTH-1:0] period_i,
    input  logic [TICK_WIDTH-1:0] pulse_width_i,
    input  logic                  imu_int_i,
    input  logic                  clr_overrun_i,
    output logic                  exttrig_o,
    output logic                  trig_event_o,
    output logic [ID_WIDTH-1:0]   trig_id_o,
    output logic                  trig_pol_o,
    output logic                  busy_o,
    output logic                  overrun_o
);

    localparam logic [TICK_WIDTH-1:0] TickOne = TICK_WIDTH'(1);
    localparam logic [ID_WIDTH-1:0]   IdOne   = ID_WIDTH'(1);

    evt_state_e            r_state;
    logic                  r_exttrig;
    logic                  r_event;
    logic                  r_pol;
    logic [ID_WIDTH-1:0]   r_id;
    logic [TICK_WIDTH-1:0] r_width;
    logic [TICK_WIDTH-1:0] r_tcnt;
    logic                  r_pending;
    logic                  r_overrun;
    logic [TICK_WIDTH-1:0] r_period_cnt;
    logic [TICK_WIDTH-1:0] r_period_last;

    logic                  w_imu_rise;
    logic                  w_mode_per;
    logic                  w_mode_imu;
    logic                  w_per_run;
    logic                  w_per_chg;
    logic                  w_per_req;
    logic                  w_req;
    logic                  w_busy;
    logic                  w_start;
    logic                  w_pend_nxt;
    logic                  w_ovr_set;
    logic [TICK_WIDTH-1:0] w_pw;

    evt_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_imu_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (imu_int_i),
        .rise_o  (w_imu_rise)
    );

    assign w_mode_per = (mode_i == MODE_PERIODIC) || (mode_i == MODE_BOTH);
    assign w_mode_imu = (mode_i == MODE_IMU) || (mode_i == MODE_BOTH);

    // A period change restarts the count and suppresses a request in that cycle
    assign w_per_run = enable_i & w_mode_per & (period_i != '0);
    assign w_per_chg = (period_i != r_period_last);
    assign w_per_req = w_per_run & ~w_per_chg & (r_period_cnt == period_i - TickOne);

    // Coincident periodic and IMU requests merge into a single request
    assign w_req      = enable_i & (w_per_req | (w_imu_rise & w_mode_imu));
    assign w_busy     = (r_state != StIdle);
    assign w_start    = w_req | (r_pending & enable_i);
    assign w_pend_nxt = enable_i & (r_pending | w_req);
    assign w_ovr_set  = w_busy & w_req & r_pending;
    assign w_pw       = (pulse_width_i == '0) ? TickOne : pulse_width_i;

    // Periodic counter: 0..period-1, held at 0 while the periodic source is off
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_period_cnt  <= '0;
            r_period_last <= '0;
        end else begin
            r_period_last <= period_i;
            if (!w_per_run || w_per_chg || w_per_req) begin
                r_period_cnt <= '0;
            end else begin
                r_period_cnt <= r_period_cnt + TickOne;
            end
        end
    end

    // Pulse FSM with registered pin/event outputs, pending slot and sticky overrun
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= StIdle;
            r_exttrig <= 1'b0;
            r_event   <= 1'b0;
            r_pol     <= 1'b0;
            r_id      <= '0;
            r_width   <= '0;
            r_tcnt    <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_event <= 1'b0;
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun_i) begin
                r_overrun <= 1'b0;
            end
            unique case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_state   <= StHigh;
                        r_exttrig <= 1'b1;
                        r_event   <= 1'b1;
                        r_pol     <= 1'b1;
                        r_width   <= w_pw;
                        r_tcnt    <= w_pw - TickOne;
                        // A fresh request alongside a pending one queues behind it
                        r_pending <= r_pending & w_req;
                    end else begin
                        r_pending <= 1'b0;
                    end
                end
                StHigh: begin
                    if (r_tcnt == '0) begin
                        r_state   <= StGap;
                        r_exttrig <= 1'b0;
                        r_event   <= 1'b1;
                        r_pol     <= 1'b0;
                        r_tcnt    <= r_width - TickOne;
                    end else begin
                        r_tcnt <= r_tcnt - TickOne;
                    end
                    r_pending <= w_pend_nxt;
                end
                StGap: begin
                    // Id advances only once the falling event has been presented
                    if (r_event) begin
                        r_id <= r_id + IdOne;
                    end
                    if (r_tcnt == '0) begin
                        r_state <= StIdle;
                    end else begin
                        r_tcnt <= r_tcnt - TickOne;
                    end
                    r_pending <= w_pend_nxt;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign exttrig_o    = r_exttrig;
    assign trig_event_o = r_event;
    assign trig_pol_o   = r_pol;
    assign trig_id_o    = r_id;
    assign busy_o       = w_busy;
    assign overrun_o    = r_overrun;

endmodule

// File: tb/tb_evt_trig_scheduler.sv
// Directed bench for evt_trig_scheduler: cycle table for the IMU path plus
// event-log sequences for periodic, overrun, coincidence, id wrap and disable/reset.
module tb_evt_trig_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [23:0] period;
    logic [23:0] pwidth;
    logic        imu;
    logic        clr;
    logic        ext;
    logic        evt;
    logic [4:0]  id;
    logic        pol;
    logic        busy;
    logic        ovr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int b      = 0;

    typedef struct {
        int   cyc;
        logic pol;
        int   id;
    } ev_t;
    ev_t evq[$];

    // {imu in} {ext, evt, pol expected} {id expected} {busy expected}
    typedef struct packed {
        logic       imu;
        logic       ext;
        logic       evt;
        logic       pol;
        logic [4:0] id;
        logic       busy;
    } vec_t;
    vec_t tbl[16];

    evt_trig_scheduler dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .enable_i      (en),
        .mode_i        (mode),
        .period_i      (period),
        .pulse_width_i (pwidth),
        .imu_int_i     (imu),
        .clr_overrun_i (clr),
        .exttrig_o     (ext),
        .trig_event_o  (evt),
        .trig_id_o     (id),
        .trig_pol_o    (pol),
        .busy_o        (busy),
        .overrun_o     (ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log, stamped with the index of the edge that produced the event
    always @(negedge clk) begin
        if (rst_n && evt) evq.push_back('{cyc: cyc, pol: pol, id: int'(id)});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [1:0] m, input logic [23:0] per, input logic [23:0] pw);
        rst_n  = 1'b0;
        en     = 1'b1;
        mode   = m;
        period = per;
        pwidth = pw;
        imu    = 1'b0;
        clr    = 1'b0;
        tick(3);
        rst_n = 1'b1;
        b = evq.size();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int a;
        int k;
        int r;

        // IMU only, pw=3: rise before edge 0 -> high after edge 3 for 3 cycles
        tbl[0]  = {4'b1000, 5'd0, 1'b0};
        tbl[1]  = {4'b1000, 5'd0, 1'b0};
        tbl[2]  = {4'b1000, 5'd0, 1'b0};
        tbl[3]  = {4'b1111, 5'd0, 1'b1};
        tbl[4]  = {4'b1101, 5'd0, 1'b1};
        tbl[5]  = {4'b1101, 5'd0, 1'b1};
        tbl[6]  = {4'b0010, 5'd0, 1'b1};
        tbl[7]  = {4'b0000, 5'd1, 1'b1};
        tbl[8]  = {4'b0000, 5'd1, 1'b1};
        tbl[9]  = {4'b0000, 5'd1, 1'b0};
        tbl[10] = {4'b0000, 5'd1, 1'b0};
        tbl[11] = {4'b0000, 5'd1, 1'b0};
        tbl[12] = {4'b1000, 5'd1, 1'b0};
        tbl[13] = {4'b1000, 5'd1, 1'b0};
        tbl[14] = {4'b1000, 5'd1, 1'b0};
        tbl[15] = {4'b1111, 5'd1, 1'b1};

        rst_n = 1'b0;
        en = 1'b1; mode = 2'd2; period = 24'd0; pwidth = 24'd3; imu = 1'b1; clr = 1'b0;
        tick(2);
        chk("reset_outputs", 32'({ext, evt, pol, id, busy, ovr}), 32'd0);

        do_reset(2'd2, 24'd0, 24'd3);
        for (int i = 0; i < 16; i++) begin
            imu = tbl[i].imu;
            tick(1);
            chk($sformatf("imu_row%0d", i), 32'({ext, evt, pol, id, busy}),
                32'({tbl[i].ext, tbl[i].evt, tbl[i].pol, tbl[i].id, tbl[i].busy}));
        end
        chk("imu_no_overrun", 32'(ovr), 32'd0);

        // Periodic only: period 10, pw 2
        do_reset(2'd1, 24'd10, 24'd2);
        tick(45);
        chk("per_enough_events", 32'(evq.size() >= b + 6), 32'd1);
        if (evq.size() >= b + 6) begin
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("per_rise_pol%0d", p), 32'(evq[b+2*p].pol), 32'd1);
                chk($sformatf("per_rise_id%0d", p), 32'(evq[b+2*p].id), 32'(p));
                chk($sformatf("per_fall_pol%0d", p), 32'(evq[b+2*p+1].pol), 32'd0);
                chk($sformatf("per_fall_id%0d", p), 32'(evq[b+2*p+1].id), 32'(p));
                chk($sformatf("per_high_len%0d", p),
                    32'(evq[b+2*p+1].cyc - evq[b+2*p].cyc), 32'd2);
                if (p > 0) begin
                    chk($sformatf("per_spacing%0d", p),
                        32'(evq[b+2*p].cyc - evq[b+2*p-2].cyc), 32'd10);
                end
            end
        end

        // Overrun: pw 20, three IMU edges 5 cycles apart inside one pulse
        do_reset(2'd2, 24'd0, 24'd20);
        imu = 1'b1; tick(1); a = cyc; tick(1); imu = 1'b0; tick(3);
        imu = 1'b1; tick(2); imu = 1'b0; tick(3);
        chk("ovr_after_second_edge", 32'(ovr), 32'd0);
        imu = 1'b1; tick(2); imu = 1'b0; tick(3);
        chk("ovr_after_third_edge", 32'(ovr), 32'd1);
        tick(60);
        chk("ovr_event_count", 32'(evq.size() - b), 32'd4);
        if (evq.size() >= b + 4) begin
            chk("ovr_rise1_time", 32'(evq[b].cyc - a), 32'd3);
            chk("ovr_high_len", 32'(evq[b+1].cyc - evq[b].cyc), 32'd20);
            chk("ovr_pending_rise", 32'(evq[b+2].cyc - evq[b].cyc), 32'd41);
            chk("ovr_pending_id", 32'(evq[b+2].id), 32'd1);
        end
        chk("ovr_sticky", 32'(ovr), 32'd1);
        clr = 1'b1; tick(1); clr = 1'b0;
        chk("ovr_cleared", 32'(ovr), 32'd0);

        // Simultaneous: IMU request lands in the same cycle as the period wrap
        do_reset(2'd3, 24'd50, 24'd2);
        for (int n = 0; n < 80 && evq.size() == b; n++) @(negedge clk);
        chk("sim_first_pulse", 32'(evq.size() > b), 32'd1);
        if (evq.size() > b) begin
            r = evq[b].cyc;
            while (cyc < r + 46) @(negedge clk);
            imu = 1'b1;
            while (cyc < r + 60) @(negedge clk);
            imu = 1'b0;
            chk("sim_event_count", 32'(evq.size() - b), 32'd4);
            if (evq.size() >= b + 3) begin
                chk("sim_second_rise", 32'(evq[b+2].cyc - r), 32'd50);
            end
            chk("sim_no_overrun", 32'(ovr), 32'd0);
        end

        // Id wrap with pw=0 (1-cycle high, 1-cycle gap), period 3
        do_reset(2'd1, 24'd3, 24'd0);
        tick(110);
        chk("wrap_enough_events", 32'(evq.size() >= b + 66), 32'd1);
        if (evq.size() >= b + 66) begin
            chk("wrap_id30", 32'(evq[b+60].id), 32'd30);
            chk("wrap_id31", 32'(evq[b+62].id), 32'd31);
            chk("wrap_id0", 32'(evq[b+64].id), 32'd0);
            chk("wrap_fall_id0", 32'(evq[b+65].id), 32'd0);
            chk("pw0_high_len", 32'(evq[b+1].cyc - evq[b].cyc), 32'd1);
            chk("pw0_gap_to_next", 32'(evq[b+2].cyc - evq[b+1].cyc), 32'd2);
        end

        // Disable mid-pulse (pw 8) with a pending request that must be discarded
        do_reset(2'd2, 24'd0, 24'd8);
        imu = 1'b1; tick(1); k = cyc; imu = 1'b0; tick(1); imu = 1'b1; tick(1);
        tick(3);
        en = 1'b0;
        tick(13);
        chk("dis_busy_in_gap", 32'(busy), 32'd1);
        tick(1);
        chk("dis_idle_after_gap", 32'(busy), 32'd0);
        tick(6);
        en = 1'b1;
        tick(10);
        chk("dis_event_count", 32'(evq.size() - b), 32'd2);
        if (evq.size() >= b + 2) begin
            chk("dis_rise_time", 32'(evq[b].cyc - k), 32'd3);
            chk("dis_full_high", 32'(evq[b+1].cyc - evq[b].cyc), 32'd8);
            chk("dis_fall_pol", 32'(evq[b+1].pol), 32'd0);
        end

        // Reset mid-HIGH: pin drops at once, id returns to 0, no falling event
        imu = 1'b0; tick(3); imu = 1'b1; tick(6);
        chk("rst_pulse_started", 32'(evq.size() - b), 32'd3);
        if (evq.size() >= b + 3) begin
            chk("rst_pulse_id", 32'(evq[b+2].id), 32'd1);
        end
        chk("rst_pin_high", 32'(ext), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_outs", 32'({ext, id, busy}), 32'd0);
        tick(3);
        chk("rst_no_fall_event", 32'(evq.size() - b), 32'd3);
        rst_n = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
